// File: rtl/perm_blk_fifo_if.sv
// Word-stream handshake bundle between the NoC side and the permutation block.
// The FIFO connects through the slave modport; its environment uses the master modport.
interface perm_blk_fifo_if #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          pushin;
    logic          firstin;
    logic [W-1:0]  din;
    logic          stopin;
    logic          pushout;
    logic          firstout;
    logic [W-1:0]  dout;
    logic          stopout;
    logic [CW-1:0] blk_cnt;
    logic          err_frame;

    modport slave (
        input  pushin, firstin, din, stopout,
        output stopin, pushout, firstout, dout, blk_cnt, err_frame
    );

    modport master (
        output pushin, firstin, din, stopout,
        input  stopin, pushout, firstout, dout, blk_cnt, err_frame
    );
endinterface

// File: rtl/perm_blk_fifo.sv
// Block-framed FIFO: buffers up to DEPTH blocks of WORDS words and recovers from framing errors.
// Optional cut-through streams the block currently being written.
module perm_blk_fifo #(
    parameter int W           = 64,
    parameter int WORDS       = 25,
    parameter int DEPTH       = 2,
    parameter int CUT_THROUGH = 0
) (
    input  logic           clk,
    input  logic           reset,
    perm_blk_fifo_if.slave bus
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = $clog2(WORDS);
    localparam int NW = DEPTH * WORDS;
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [IW-1:0] LAST_IX   = IW'(WORDS - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [W-1:0]  mem_q [NW];

    logic [SW-1:0] wslot_q, wslot_d;
    logic [SW-1:0] rslot_q, rslot_d;
    logic [IW-1:0] wix_q, wix_d;
    logic [IW-1:0] rix_q, rix_d;
    logic [CW-1:0] blk_cnt_q, blk_cnt_d;
    logic          err_q, err_d;

    logic          full;
    logic          ct_live;
    logic          out_valid;
    logic          wr_fire;
    logic          wr_store;
    logic          discard;
    logic          commit;
    logic          rd_fire;
    logic          rd_last;
    logic [IW-1:0] wr_ix;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        full      = (blk_cnt_q == FULL_CNT);
        ct_live   = (CUT_THROUGH != 0) && (blk_cnt_q == '0) && (rslot_q == wslot_q);
        out_valid = (blk_cnt_q != '0) || (ct_live && (rix_q < wix_q));

        wr_fire   = bus.pushin && !full;
        wr_store  = wr_fire && (bus.firstin || (wix_q != '0));
        discard   = wr_fire && bus.firstin && (wix_q != '0);
        err_d     = discard || (wr_fire && !bus.firstin && (wix_q == '0));
        wr_ix     = bus.firstin ? '0 : wix_q;
        commit    = wr_store && (wr_ix == LAST_IX);

        rd_fire   = out_valid && !bus.stopout;
        rd_last   = rd_fire && (rix_q == LAST_IX);

        waddr     = AW'(wslot_q) * AW'(WORDS) + AW'(wr_ix);
        raddr     = AW'(rslot_q) * AW'(WORDS) + AW'(rix_q);
    end

    always_comb begin
        wslot_d   = wslot_q;
        rslot_d   = rslot_q;
        wix_d     = wix_q;
        rix_d     = rix_q;
        blk_cnt_d = blk_cnt_q;

        if (wr_store) begin
            wix_d = commit ? '0 : wr_ix + 1'b1;
        end
        if (commit) begin
            wslot_d = (wslot_q == LAST_SLOT) ? '0 : wslot_q + 1'b1;
        end

        if (rd_fire) begin
            rix_d = rd_last ? '0 : rix_q + 1'b1;
        end
        // A restarted in-progress block is re-emitted from word 0 with a fresh firstout.
        if (discard && ct_live) begin
            rix_d = '0;
        end
        // The last word only becomes readable after its block commits, so this read always frees a slot.
        if (rd_last) begin
            rslot_d = (rslot_q == LAST_SLOT) ? '0 : rslot_q + 1'b1;
        end

        case ({commit, rd_last})
            2'b10:   blk_cnt_d = blk_cnt_q + 1'b1;
            2'b01:   blk_cnt_d = blk_cnt_q - 1'b1;
            default: blk_cnt_d = blk_cnt_q;
        endcase
    end

    // NOTE: storage has no reset; words are only exposed behind out_valid, which reset clears.
    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem_q[waddr] <= bus.din;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wslot_q   <= '0;
            rslot_q   <= '0;
            wix_q     <= '0;
            rix_q     <= '0;
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wslot_q   <= wslot_d;
            rslot_q   <= rslot_d;
            wix_q     <= wix_d;
            rix_q     <= rix_d;
            blk_cnt_q <= blk_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.stopin    = full;
    assign bus.pushout   = out_valid;
    assign bus.firstout  = out_valid && (rix_q == '0);
    assign bus.dout      = out_valid ? mem_q[raddr] : '0;
    assign bus.blk_cnt   = blk_cnt_q;
    assign bus.err_frame = err_q;
endmodule

// File: tb/tb_perm_blk_fifo.sv
// Bench for perm_blk_fifo: a store-and-forward and a cut-through instance, each shadowed by a
// queue-based block model compared every cycle, plus hand-computed spot checks.
module tb_perm_blk_fifo;
    localparam int W     = 64;
    localparam int WORDS = 25;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         pushin  = 1'b0;
    logic         firstin = 1'b0;
    logic         stopout = 1'b0;
    logic [W-1:0] din     = '0;
    int           drv_sel = 0;

    int n_total = 0;
    int n_bad   = 0;
    int rd_cnt0 = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam bit CT = (g == 1);

        perm_blk_fifo_if #(.W(W), .DEPTH(DEPTH)) bus ();

        perm_blk_fifo #(
            .W(W), .WORDS(WORDS), .DEPTH(DEPTH), .CUT_THROUGH(g)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.pushin  = pushin && (drv_sel == g);
        assign bus.firstin = firstin;
        assign bus.din     = din;
        assign bus.stopout = stopout;

        // Model: committed words in order, the partial block, and the read offset.
        logic [W-1:0] cw[$];
        logic [W-1:0] pw[$];
        int           rpos  = 0;
        logic         err_e = 1'b0;
        int           ncb_m;
        bit           pe_m, rd_m, wr_m, empty_m;

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                cw.delete();
                pw.delete();
                rpos  = 0;
                err_e = 1'b0;
            end else begin
                ncb_m   = cw.size() / WORDS;
                empty_m = (ncb_m == 0);
                pe_m    = !empty_m || (CT && rpos < pw.size());
                rd_m    = pe_m && !bus.stopout;
                wr_m    = bus.pushin && (ncb_m != DEPTH);
                err_e   = 1'b0;
                if (rd_m) begin
                    rpos++;
                    if (rpos == WORDS) begin
                        repeat (WORDS) void'(cw.pop_front());
                        rpos = 0;
                    end
                end
                if (wr_m) begin
                    if (bus.firstin) begin
                        if (pw.size() != 0) begin
                            err_e = 1'b1;
                            if (empty_m) rpos = 0;
                        end
                        pw.delete();
                        pw.push_back(bus.din);
                    end else if (pw.size() == 0) begin
                        err_e = 1'b1;
                    end else begin
                        pw.push_back(bus.din);
                        if (pw.size() == WORDS) begin
                            for (int k = 0; k < WORDS; k++) cw.push_back(pw[k]);
                            pw.delete();
                        end
                    end
                end
            end
        end

        int           ncb_c;
        logic         pe_c;
        logic [W-1:0] de_c;

        always @(negedge clk) begin
            ncb_c = cw.size() / WORDS;
            if (ncb_c != 0) begin
                pe_c = 1'b1;
                de_c = cw[rpos];
            end else if (CT && rpos < pw.size()) begin
                pe_c = 1'b1;
                de_c = pw[rpos];
            end else begin
                pe_c = 1'b0;
                de_c = '0;
            end
            check($sformatf("i%0d pushout", g),   W'(bus.pushout),   W'(pe_c));
            check($sformatf("i%0d firstout", g),  W'(bus.firstout),  W'(pe_c && rpos == 0));
            check($sformatf("i%0d dout", g),      bus.dout,          de_c);
            check($sformatf("i%0d stopin", g),    W'(bus.stopin),    W'(ncb_c == DEPTH));
            check($sformatf("i%0d blk_cnt", g),   W'(bus.blk_cnt),   W'(ncb_c));
            check($sformatf("i%0d err_frame", g), W'(bus.err_frame), W'(err_e));
        end
    end

    always @(posedge clk) begin
        if (reset && u[0].bus.pushout && !u[0].bus.stopout) rd_cnt0++;
    end

    logic sel_stopin;
    assign sel_stopin = (drv_sel == 0) ? u[0].bus.stopin : u[1].bus.stopin;

    function automatic logic po(input int i);
        return (i == 0) ? u[0].bus.pushout : u[1].bus.pushout;
    endfunction

    function automatic logic [CW-1:0] bc(input int i);
        return (i == 0) ? u[0].bus.blk_cnt : u[1].bus.blk_cnt;
    endfunction

    // Called at a falling edge; returns at the falling edge after the word is accepted.
    task automatic send(input logic f, input logic [W-1:0] d);
        int guard = 0;
        pushin  = 1'b1;
        firstin = f;
        din     = d;
        while (sel_stopin && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (sel_stopin) begin
            n_total++;
            n_bad++;
            $display("FAIL send_timeout: word %0h never accepted", d);
        end else begin
            @(negedge clk);
        end
        pushin  = 1'b0;
        firstin = 1'b0;
    endtask

    task automatic wait_idle(input int inst, input string name);
        int k = 0;
        while (k < 300 && (po(inst) || bc(inst) != 0)) begin
            @(negedge clk);
            k++;
        end
        check({name, " drained"}, W'(po(inst) || bc(inst) != 0), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd_before;

        repeat (2) @(negedge clk);
        check("reset pushout", W'(u[0].bus.pushout), W'(0));
        check("reset stopin",  W'(u[0].bus.stopin),  W'(0));
        check("reset blk_cnt", W'(u[0].bus.blk_cnt), W'(0));
        reset = 1'b1;
        @(negedge clk);

        // Single block, store-and-forward.
        for (int i = 0; i < WORDS; i++) send(i == 0, W'(i));
        check("t1 pushout",  W'(u[0].bus.pushout),  W'(1));
        check("t1 firstout", W'(u[0].bus.firstout), W'(1));
        check("t1 blk_cnt",  W'(u[0].bus.blk_cnt),  W'(1));
        for (int i = 0; i < WORDS; i++) begin
            check("t1 word", u[0].bus.dout, W'(i));
            check("t1 first", W'(u[0].bus.firstout), W'(i == 0));
            @(negedge clk);
        end
        check("t1 end blk_cnt", W'(u[0].bus.blk_cnt), W'(0));
        check("t1 end pushout", W'(u[0].bus.pushout), W'(0));

        // Three blocks against a stalled downstream.
        rd_before = rd_cnt0;
        stopout = 1'b1;
        for (int b = 1; b <= 2; b++)
            for (int i = 0; i < WORDS; i++) send(i == 0, W'(b * 256 + i));
        check("t2 stopin",  W'(u[0].bus.stopin),  W'(1));
        check("t2 blk_cnt", W'(u[0].bus.blk_cnt), W'(2));
        fork
            for (int i = 0; i < WORDS; i++) send(i == 0, W'(3 * 256 + i));
            begin
                repeat (10) begin
                    @(negedge clk);
                    check("t2 frozen dout", u[0].bus.dout, W'(64'h100));
                end
                stopout = 1'b0;
            end
        join
        wait_idle(0, "t2");
        check("t2 words read", W'(rd_cnt0 - rd_before), W'(3 * WORDS));

        // Framing errors: restart at word 10, then a stray word without firstin.
        for (int i = 0; i < 10; i++) send(i == 0, W'(64'h300 + i));
        send(1'b1, W'(64'h400));
        check("t3 err pulse", W'(u[0].bus.err_frame), W'(1));
        send(1'b0, W'(64'h401));
        check("t3 err clear", W'(u[0].bus.err_frame), W'(0));
        for (int i = 2; i < WORDS; i++) send(1'b0, W'(64'h400 + i));
        check("t3 first word", u[0].bus.dout, W'(64'h400));
        check("t3 firstout",   W'(u[0].bus.firstout), W'(1));
        wait_idle(0, "t3");
        send(1'b0, W'(64'hdead));
        check("t3 stray err",     W'(u[0].bus.err_frame), W'(1));
        check("t3 stray blk_cnt", W'(u[0].bus.blk_cnt),   W'(0));
        check("t3 stray pushout", W'(u[0].bus.pushout),   W'(0));

        // Commit and last-word read on the same edge.
        stopout = 1'b1;
        for (int b = 5; b <= 6; b++)
            for (int i = 0; i < WORDS; i++) send(i == 0, W'(b * 256 + i));
        fork
            for (int i = 0; i < WORDS; i++) send(i == 0, W'(7 * 256 + i));
            begin
                repeat (3) @(negedge clk);
                stopout = 1'b0;
            end
        join
        check("t4 blk_cnt", W'(u[0].bus.blk_cnt),  W'(1));
        check("t4 dout",    u[0].bus.dout,          W'(64'h700));
        check("t4 first",   W'(u[0].bus.firstout), W'(1));
        wait_idle(0, "t4");

        // Cut-through instance: latency, input gap, and restart after emission.
        drv_sel = 1;
        send(1'b1, W'(0));
        check("t5 pushout",  W'(u[1].bus.pushout),  W'(1));
        check("t5 firstout", W'(u[1].bus.firstout), W'(1));
        check("t5 dout",     u[1].bus.dout,          W'(0));
        for (int i = 1; i < 12; i++) send(1'b0, W'(i));
        check("t5 word11", u[1].bus.dout, W'(11));
        repeat (5) begin
            @(negedge clk);
            check("t5 gap pushout", W'(u[1].bus.pushout), W'(0));
        end
        send(1'b0, W'(12));
        check("t5 resume pushout", W'(u[1].bus.pushout), W'(1));
        check("t5 resume dout",    u[1].bus.dout,         W'(12));
        for (int i = 13; i < WORDS; i++) send(1'b0, W'(i));
        wait_idle(1, "t5");

        for (int i = 0; i < 6; i++) send(i == 0, W'(64'h900 + i));
        send(1'b1, W'(64'ha00));
        check("t5 restart first", W'(u[1].bus.firstout),  W'(1));
        check("t5 restart dout",  u[1].bus.dout,           W'(64'ha00));
        check("t5 restart err",   W'(u[1].bus.err_frame), W'(1));
        for (int i = 1; i < WORDS; i++) send(1'b0, W'(64'ha00 + i));
        wait_idle(1, "t5b");

        // Reset in the middle of a block.
        drv_sel = 0;
        stopout = 1'b1;
        for (int i = 0; i < WORDS; i++) send(i == 0, W'(64'hc00 + i));
        for (int i = 0; i < 13; i++) send(i == 0, W'(64'hd00 + i));
        check("t6 pre blk_cnt", W'(u[0].bus.blk_cnt), W'(1));
        #2 reset = 1'b0;
        #1;
        check("t6 rst pushout",  W'(u[0].bus.pushout),  W'(0));
        check("t6 rst firstout", W'(u[0].bus.firstout), W'(0));
        check("t6 rst dout",     u[0].bus.dout,          W'(0));
        check("t6 rst blk_cnt",  W'(u[0].bus.blk_cnt),  W'(0));
        check("t6 rst stopin",   W'(u[0].bus.stopin),   W'(0));
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        stopout = 1'b0;
        @(negedge clk);
        for (int i = 0; i < WORDS; i++) send(i == 0, W'(64'he00 + i));
        check("t6 fresh dout", u[0].bus.dout, W'(64'he00));
        wait_idle(0, "t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
